crc16_dec_arbiter: RTL and testbench

Frame-level arbiter and sequencer sharing one CRC16 decoder between two 32-bit word requesters. It grants a whole frame to one requester and pulses the decoder's `sync` one cycle before the first word. It then streams the frame's words contiguously into the decoder's `Data` input and routes the decoder's `correct_code` back out, tagged with requester id and frame-end flags. The decoder has no enable and updates its state every cycle, so the arbiter enforces gap-free frames and aborts any frame that stalls.

---
 rtl/crc16_dec_arbiter.sv | 135 +++++++++++++
 tb/tb_crc16_dec_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_dec_arbiter.sv
// Frame arbiter sharing one CRC16 decoder between two 32-bit word requesters.
// Optional feature: define CRC16_ARB_RR_EN for round-robin; default is fixed priority (req0 wins).
module crc16_dec_arbiter #(
  parameter int MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        dec_sync,
  output logic [31:0] dec_data,
  input  logic [31:0] dec_correct_code,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic        out_last,
  output logic        out_trunc,
  output logic        out_abort,
  output logic        busy
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]    state;
  logic          gnt;
  logic [CW-1:0] count;

  logic          sel_valid;
  logic          sel_last;
  logic [31:0]   sel_data;
  logic          win;
  logic          at_limit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_valid = req0_valid;
    sel_last  = req0_last;
    sel_data  = req0_data;
    if (gnt) begin
      sel_valid = req1_valid;
      sel_last  = req1_last;
      sel_data  = req1_data;
    end
  end

  // The word being accepted now is the MAX_WORDS-th of the frame.
  assign at_limit = (count == CW'(MAX_WORDS - 1));

`ifdef CRC16_ARB_RR_EN
  // rr_ptr names the requester that wins the next tie; it moves off whoever was just served.
  logic rr_ptr;
  logic frame_end;

  assign frame_end = (state == S_STREAM) && (!sel_valid || sel_last || at_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (frame_end) begin
      rr_ptr <= ~gnt;
    end
  end

  assign win = (req0_valid && req1_valid) ? rr_ptr : ~req0_valid;
`else
  assign win = ~req0_valid;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
      out_abort <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
      out_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt   <= win;
            state <= S_SYNC;
          end
        end
        S_SYNC: begin
          count <= '0;
          state <= S_STREAM;
        end
        S_STREAM: begin
          // The decoder cannot pause, so any gap kills the frame.
          if (!sel_valid) begin
            out_abort <= 1'b1;
            out_id    <= gnt;
            state     <= S_IDLE;
          end else begin
            count     <= count + CW'(1);
            out_valid <= 1'b1;
            out_id    <= gnt;
            out_last  <= sel_last || at_limit;
            out_trunc <= !sel_last && at_limit;
            if (sel_last || at_limit) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign dec_sync   = (state == S_SYNC);
  assign req0_ready = (state == S_STREAM) && !gnt;
  assign req1_ready = (state == S_STREAM) &&  gnt;
  assign dec_data   = (state == S_STREAM) ? sel_data : 32'h0;
  assign out_data   = dec_correct_code;

endmodule

// File: tb/tb_crc16_dec_arbiter.sv
// Self-checking bench for crc16_dec_arbiter: directed vector table, hand sequences, random vs reference model.
module tb_crc16_dec_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        dec_sync;
  logic [31:0] dec_data;
  logic [31:0] dec_correct_code;
  logic        out_valid, out_id, out_last, out_trunc, out_abort, busy;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  crc16_dec_arbiter #(.MAX_WORDS(MW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_data        (req0_data),
    .req0_last        (req0_last),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_data        (req1_data),
    .req1_last        (req1_last),
    .req1_ready       (req1_ready),
    .dec_sync         (dec_sync),
    .dec_data         (dec_data),
    .dec_correct_code (dec_correct_code),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_id           (out_id),
    .out_last         (out_last),
    .out_trunc        (out_trunc),
    .out_abort        (out_abort),
    .busy             (busy)
  );

  // Error-free decoder stand-in: one register stage.
  always_ff @(posedge clk) dec_correct_code <= dec_data;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame phase (0 idle, 1 sync, 2 stream), owner, words sent in frame, tie winner.
  int          m_phase = 0;
  bit          m_owner = 0;
  int          m_words = 0;
  bit          m_prio  = 0;
  bit          m_ov = 0, m_last = 0, m_trunc = 0, m_abort = 0, m_id = 0;
  logic [31:0] m_word = '0;

  function automatic logic [7:0] dut_ctl();
    return {req0_ready, req1_ready, dec_sync, busy, out_valid, out_last, out_trunc, out_abort};
  endfunction

  function automatic logic [31:0] m_dec_data();
    if (m_phase != 2) return 32'h0;
    return m_owner ? req1_data : req0_data;
  endfunction

  task automatic apply(input logic rst, input logic v0, input logic l0, input logic [31:0] d0,
                       input logic v1, input logic l1, input logic [31:0] d1);
    reset = rst;
    req0_valid = v0; req0_last = l0; req0_data = d0;
    req1_valid = v1; req1_last = l1; req1_data = d1;
    @(negedge clk);
    check("ctl", dut_ctl(), {m_phase == 2 && !m_owner, m_phase == 2 && m_owner, m_phase == 1,
                             m_phase != 0, m_ov, m_last, m_trunc, m_abort});
    check("dec_data", dec_data, m_dec_data());
    if (m_ov) check("out_data", out_data, m_word);
    if (m_ov || m_abort) check("out_id", out_id, m_id);
  endtask

  task automatic tick();
    logic [31:0] dd;
    bit vg, lg, tie;
    dd = m_dec_data();
    if (reset) begin
      m_phase = 0; m_words = 0; m_prio = 0;
      m_ov = 0; m_last = 0; m_trunc = 0; m_abort = 0; m_id = 0;
    end else begin
      m_ov = 0; m_last = 0; m_trunc = 0; m_abort = 0;
      m_word = dd;
      case (m_phase)
        0: if (req0_valid || req1_valid) begin
`ifdef CRC16_ARB_RR_EN
             tie = req0_valid && req1_valid;
             m_owner = tie ? m_prio : !req0_valid;
`else
             tie = 0;
             m_owner = !req0_valid;
`endif
             m_phase = 1;
           end
        1: begin m_phase = 2; m_words = 0; end
        default: begin
          vg = m_owner ? req1_valid : req0_valid;
          lg = m_owner ? req1_last  : req0_last;
          m_id = m_owner;
          if (!vg) begin
            m_abort = 1; m_phase = 0; m_prio = !m_owner;
          end else begin
            m_words++;
            m_ov = 1;
            m_last  = lg || (m_words == MW);
            m_trunc = !lg && (m_words == MW);
            if (m_last) begin m_phase = 0; m_prio = !m_owner; end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v0, l0; logic [31:0] d0;
    logic v1, l1; logic [31:0] d1;
    logic [7:0] ctl;  // {r0, r1, sync, busy, ov, last, trunc, abort}
    logic id; logic [31:0] data;
  } vec_t;

  typedef struct { logic [31:0] data; logic last, trunc; } ev_t;

  vec_t tbl[17];
  ev_t  evq[$];
  bit   grants[$];

  initial begin
    int idx0, idx1, nsync;
    bit seen_abort;

    tbl[0]  = '{1, 0, 32'h1,        0, 0, 32'h0,        8'b0000_0000, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h1,        0, 0, 32'h0,        8'b0011_0000, 0, 32'h0};
    tbl[2]  = '{1, 0, 32'h1,        0, 0, 32'h0,        8'b1001_0000, 0, 32'h0};
    tbl[3]  = '{1, 0, 32'h12345678, 0, 0, 32'h0,        8'b1001_1000, 0, 32'h1};
    tbl[4]  = '{1, 1, 32'hDEADBEEF, 0, 0, 32'h0,        8'b1001_1000, 0, 32'h12345678};
    tbl[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,        8'b0000_1100, 0, 32'hDEADBEEF};
    tbl[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,        8'b0000_0000, 0, 32'h0};
    tbl[7]  = '{0, 0, 32'h0,        1, 0, 32'hA1A10001, 8'b0000_0000, 0, 32'h0};
    tbl[8]  = '{0, 0, 32'h0,        1, 0, 32'hA1A10001, 8'b0011_0000, 0, 32'h0};
    tbl[9]  = '{0, 0, 32'h0,        1, 0, 32'hA1A10001, 8'b0101_0000, 0, 32'h0};
    tbl[10] = '{0, 0, 32'h0,        1, 0, 32'hA1A10002, 8'b0101_1000, 1, 32'hA1A10001};
    tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        8'b0101_1000, 1, 32'hA1A10002};
    tbl[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        8'b0000_0001, 1, 32'h0};
    tbl[13] = '{0, 0, 32'h0,        1, 1, 32'hB1B10001, 8'b0000_0000, 0, 32'h0};
    tbl[14] = '{0, 0, 32'h0,        1, 1, 32'hB1B10001, 8'b0011_0000, 0, 32'h0};
    tbl[15] = '{0, 0, 32'h0,        1, 1, 32'hB1B10001, 8'b0101_0000, 0, 32'h0};
    tbl[16] = '{0, 0, 32'h0,        0, 0, 32'h0,        8'b0000_1100, 1, 32'hB1B10001};

    reset = 1'b1;
    req0_valid = 0; req0_last = 0; req0_data = '0;
    req1_valid = 0; req1_last = 0; req1_data = '0;
    @(posedge clk);
    #1;

    // Reset state
    apply(1, 0, 0, 0, 0, 0, 0);
    check("reset_outs", {dut_ctl(), out_id, dec_data}, 41'h0);
    tick();

    // Directed table: 3-word frame on req0, then 2-word req1 frame aborted by a gap, then re-grant.
    for (int i = 0; i < 17; i++) begin
      apply(0, tbl[i].v0, tbl[i].l0, tbl[i].d0, tbl[i].v1, tbl[i].l1, tbl[i].d1);
      check($sformatf("tbl%0d_ctl", i), dut_ctl(), tbl[i].ctl);
      if (tbl[i].ctl[3]) check($sformatf("tbl%0d_data", i), out_data, tbl[i].data);
      if (tbl[i].ctl[3] || tbl[i].ctl[0]) check($sformatf("tbl%0d_id", i), out_id, tbl[i].id);
      tick();
    end

    // Truncation: 6 words with last on the sixth become a 4-word cut frame plus a 2-word frame.
    idx0 = 0; nsync = 0;
    for (int c = 0; c < 30; c++) begin
      apply(0, idx0 < 6, idx0 == 5, 32'(idx0 + 1), 0, 0, 0);
      if (dec_sync) nsync++;
      if (out_valid) evq.push_back('{out_data, out_last, out_trunc});
      if (req0_ready && idx0 < 6) idx0++;
      tick();
    end
    check("trunc_nwords", evq.size(), 6);
    check("trunc_nsync", nsync, 2);
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      check($sformatf("trunc_w%0d", i), {evq[i].data, evq[i].last, evq[i].trunc},
            {32'(i + 1), (i == 3 || i == 5), (i == 3)});
    end

    // Contention: both requesters continuously valid with 2-word frames.
    apply(1, 0, 0, 0, 0, 0, 0);
    tick();
    idx0 = 0; idx1 = 0;
    for (int c = 0; c < 30; c++) begin
      apply(0, 1, idx0 == 1, 32'h100 + 32'(idx0), 1, idx1 == 1, 32'h200 + 32'(idx1));
      if (out_valid && out_last) grants.push_back(out_id);
      if (req0_ready) idx0 = (idx0 + 1) % 2;
      if (req1_ready) idx1 = (idx1 + 1) % 2;
      tick();
    end
    check("cont_nframes", grants.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef CRC16_ARB_RR_EN
      check($sformatf("cont_gnt%0d", i), grants[i], i % 2);
`else
      check($sformatf("cont_gnt%0d", i), grants[i], 0);
`endif
    end

    // Reset during the second STREAM word.
    apply(1, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 1, 0, 32'h11, 0, 0, 0); tick();
    apply(0, 1, 0, 32'h11, 0, 0, 0); tick();
    apply(0, 1, 0, 32'h11, 0, 0, 0); tick();
    apply(1, 1, 0, 32'h22, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_outs", {dut_ctl(), out_id, dec_data}, 41'h0);
    tick();
    seen_abort = 0;
    for (int c = 0; c < 4; c++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      seen_abort |= out_abort;
      tick();
    end
    check("rst_mid_no_abort", seen_abort, 0);
    apply(0, 1, 1, 32'h33, 0, 0, 0); tick();
    apply(0, 1, 1, 32'h33, 0, 0, 0);
    check("rst_regrant_sync", dec_sync, 1);
    tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      apply($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
